servo_slew_sequencer: RTL and testbench
=======================================

Name: servo_slew_sequencer

Overview:
- Upstream feeder for the robot arm PWM generator. Accepts per-channel servo position commands over a valid/ready interface.
- Once per servo frame, moves each channel's current position toward its target by at most STEP. Channels are scanned one per clock by a small FSM.
- Publishes a coherent flat duty bus that the PWM stage consumes, plus a one-cycle update strobe.

Parameters:
- NUM_CH, 6, number of servo channels (1..8)
- POS_W, 8, position/duty width per channel
- UPDATE_DIV, 1000000, clocks per frame (20 ms at 50 MHz); must be >= NUM_CH+2
- STEP, 4, maximum position change per channel per frame (>=1)
- POS_MIN, 16, lowest legal position
- POS_MAX, 240, highest legal position
- POS_HOME, 128, reset position for every channel (POS_MIN <= POS_HOME <= POS_MAX)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_ch  in  3  target channel index
- cmd_pos  in  POS_W  requested position
- cmd_err  out  1  one-cycle pulse: command channel index out of range
- duty_flat  out  NUM_CH*POS_W  committed positions, channel k at bits [k*POS_W +: POS_W]
- update_strobe  out  1  one-cycle pulse when duty_flat changes value set
- all_settled  out  1  every committed position equals its target

Behaviour:
- Reset: clk and reset are the only clock and reset. Reset is asynchronous, active-low.
  - While reset is low, all targets, current positions and duty_flat slices = POS_HOME.
  - Frame counter = 0; FSM = IDLE.
  - cmd_ready = 0, cmd_err = 0, update_strobe = 0, all_settled = 1.
- Reset mid-frame: reset asserted in any state aborts immediately to the reset values above. No partial duty_flat commit occurs.
- cmd_ready: 1 in every cycle after reset deassertion. A command is accepted in any FSM state when cmd_valid && cmd_ready.
- Accepted command, cmd_ch < NUM_CH: target[cmd_ch] <= clamp(cmd_pos, POS_MIN, POS_MAX), effective from the next cycle.
- Accepted command, cmd_ch >= NUM_CH: dropped; cmd_err = 1 in the following cycle only.
- Frame counter: counts 0..UPDATE_DIV-1 and wraps, free-running and independent of the FSM. Terminal count occurs in cycle T.
- FSM states:
  - IDLE: waits for terminal count, then -> SCAN with idx = 0.
  - SCAN: one channel per cycle, idx 0..NUM_CH-1, covering cycles T+1..T+NUM_CH. -> COMMIT after idx = NUM_CH-1.
  - COMMIT: one cycle (T+NUM_CH+1); -> IDLE.
- SCAN update rule for channel idx, with d = target - current:
  - If |d| <= STEP: current <= target.
  - Otherwise current <= current ± STEP, toward target.
  - Use POS_W+1-bit signed difference; no wrap-around is possible because both operands lie in [POS_MIN, POS_MAX].
- Target written in the same cycle its channel is scanned: the scan uses the old target. The new target applies from the next frame.
- COMMIT registers:
  - duty_flat <= all current values.
  - update_strobe = 1 for exactly the cycle T+NUM_CH+2, the first cycle duty_flat shows the new values.
  - all_settled <= (current == target for all channels), evaluated on post-scan values.
- duty_flat changes only at commit, so the PWM stage never sees a partially updated set.
- update_strobe pulses every frame even when no value changed.
- all_settled holds between commits. An accepted command that changes any target to a value differing from that channel's committed position drops all_settled to 0 in the next cycle.

Test Plan (UPDATE_DIV=10, STEP=4, NUM_CH=6, POS_HOME=128):
- Reset release: hold reset low 3 cycles, then release. Required: duty_flat = 128 on every channel, all_settled = 1, cmd_ready = 1 one cycle after release, update_strobe every 10 clocks, duty_flat unchanged.
- Slew: command ch2 = 140. Required: ch2 commits 132, 136, 140 on three consecutive strobes; all_settled = 0 until the third strobe, then 1; other channels stay at 128.
- Clamp and sub-step: command ch0 = 250. Required: target clamps to 240, ch0 ramps +4 per frame and ends exactly at 240. Then command ch0 = 238: a single commit to 238.
- Bad index: command ch = 7, pos = 50. Required: cmd_err pulses for exactly 1 cycle; no target changes; all_settled remains 1.
- Collision: write ch1 = 100 in the cycle ch1 is scanned. Required: the next commit shows ch1 = 128 and the following commit shows ch1 = 124.
- Mid-frame reset: assert reset during SCAN with ch3 ramping. Required: immediately all outputs return to reset values; no update_strobe; normal frames resume after release.

Source files
------------

// File: rtl/servo_slew_sequencer.sv
// Slew-limited servo position sequencer: accepts per-channel targets, steps each
// channel toward its target once per frame, and publishes a coherent duty bus.
module servo_slew_sequencer #(
  parameter int NUM_CH     = 6,
  parameter int POS_W      = 8,
  parameter int UPDATE_DIV = 1000000,
  parameter int STEP       = 4,
  parameter int POS_MIN    = 16,
  parameter int POS_MAX    = 240,
  parameter int POS_HOME   = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_ch,
  input  logic [POS_W-1:0]        cmd_pos,
  output logic                    cmd_err,
  output logic [NUM_CH*POS_W-1:0] duty_flat,
  output logic                    update_strobe,
  output logic                    all_settled
);

  localparam int CNT_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [POS_W-1:0] HOME  = POS_W'(POS_HOME);
  localparam logic [POS_W-1:0] P_MIN = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] P_MAX = POS_W'(POS_MAX);
  localparam logic signed [POS_W:0] STEP_S = (POS_W+1)'(STEP);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t           state, state_nx;
  logic [2:0]       idx, idx_nx;
  logic             scan_en, commit_en;
  logic [CNT_W-1:0] frame_cnt;
  logic             frame_tc;

  logic [POS_W-1:0] target  [NUM_CH];
  logic [POS_W-1:0] current [NUM_CH];
  logic [POS_W-1:0] duty    [NUM_CH];

  logic             accept, ch_ok, wr_en, settled_nx;
  logic [POS_W-1:0] cmd_clamped;

  // Move cur toward tgt by at most STEP; operands are in range so the
  // one-bit-wider signed difference cannot wrap.
  function automatic logic [POS_W-1:0] slew(input logic [POS_W-1:0] cur,
                                            input logic [POS_W-1:0] tgt);
    logic signed [POS_W:0] d;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (d > STEP_S)       return cur + POS_W'(STEP);
    else if (d < -STEP_S) return cur - POS_W'(STEP);
    else                  return tgt;
  endfunction

  assign frame_tc = (frame_cnt == CNT_W'(UPDATE_DIV - 1));

  // NOTE: every register is written with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      state     <= IDLE;
      idx       <= '0;
    end else begin
      frame_cnt <= frame_tc ? '0 : frame_cnt + CNT_W'(1);
      state     <= state_nx;
      idx       <= idx_nx;
    end
  end

  // NOTE: each comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    scan_en   = 1'b0;
    commit_en = 1'b0;
    case (state)
      IDLE: if (frame_tc) begin
        state_nx = SCAN;
        idx_nx   = '0;
      end
      SCAN: begin
        scan_en = 1'b1;
        if (idx == 3'(NUM_CH - 1)) state_nx = COMMIT;
        else                       idx_nx   = idx + 3'd1;
      end
      COMMIT: begin
        commit_en = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = cmd_valid && cmd_ready;
  assign ch_ok  = ({1'b0, cmd_ch} < 4'(NUM_CH));
  assign wr_en  = accept && ch_ok;

  always_comb begin
    cmd_clamped = cmd_pos;
    if (cmd_pos < P_MIN)      cmd_clamped = P_MIN;
    else if (cmd_pos > P_MAX) cmd_clamped = P_MAX;
  end

  // A commit re-evaluates settledness; a write that departs from the value being
  // (or already) committed clears it.
  always_comb begin
    settled_nx = all_settled;
    if (commit_en) begin
      settled_nx = 1'b1;
      for (int k = 0; k < NUM_CH; k++)
        if (current[k] != target[k]) settled_nx = 1'b0;
    end
    for (int k = 0; k < NUM_CH; k++)
      if (wr_en && cmd_ch == 3'(k) &&
          cmd_clamped != (commit_en ? current[k] : duty[k]))
        settled_nx = 1'b0;
  end

  // NOTE: the position arrays are a handful of flops that must come up at HOME, so they are reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        target[k]  <= HOME;
        current[k] <= HOME;
        duty[k]    <= HOME;
      end
      cmd_ready     <= 1'b0;
      cmd_err       <= 1'b0;
      update_strobe <= 1'b0;
      all_settled   <= 1'b1;
    end else begin
      cmd_ready     <= 1'b1;
      cmd_err       <= accept && !ch_ok;
      update_strobe <= commit_en;
      all_settled   <= settled_nx;
      for (int k = 0; k < NUM_CH; k++) begin
        if (scan_en && idx == 3'(k))   current[k] <= slew(current[k], target[k]);
        if (wr_en && cmd_ch == 3'(k))  target[k]  <= cmd_clamped;
        if (commit_en)                 duty[k]    <= current[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_flat
    assign duty_flat[k*POS_W +: POS_W] = duty[k];
  end

endmodule

// File: tb/tb_servo_slew_sequencer.sv
// Self-checking bench: a frame-phase model of the sequencer is compared against
// the DUT every cycle, with directed scenarios pinned by literal expectations.
module tb_servo_slew_sequencer;

  localparam int NUM_CH = 6, POS_W = 8, UPDATE_DIV = 10, STEP = 4;
  localparam int POS_MIN = 16, POS_MAX = 240, POS_HOME = 128;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    cmd_valid, cmd_ready, cmd_err;
  logic [2:0]              cmd_ch;
  logic [POS_W-1:0]        cmd_pos;
  logic [NUM_CH*POS_W-1:0] duty_flat;
  logic                    update_strobe, all_settled;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  always #5 clk = ~clk;

  servo_slew_sequencer #(
    .NUM_CH(NUM_CH), .POS_W(POS_W), .UPDATE_DIV(UPDATE_DIV), .STEP(STEP),
    .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_HOME(POS_HOME)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .cmd_err(cmd_err), .duty_flat(duty_flat),
    .update_strobe(update_strobe), .all_settled(all_settled)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cycle n after reset release has frame phase n % UPDATE_DIV; from the second
  // frame on, phases 0..NUM_CH-1 step one channel each and phase NUM_CH commits.
  int m_tgt [NUM_CH];
  int m_cur [NUM_CH];
  int m_duty[NUM_CH];
  int m_n;
  bit m_ready, m_err, m_strobe, m_settled;
  int mphase, mch, mnew;
  bit macc;

  function automatic int slew_to(int c, int t);
    if (t - c > STEP) return c + STEP;
    if (c - t > STEP) return c - STEP;
    return t;
  endfunction

  function automatic int clamp(int p);
    return (p < POS_MIN) ? POS_MIN : (p > POS_MAX) ? POS_MAX : p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_tgt[k] = POS_HOME; m_cur[k] = POS_HOME; m_duty[k] = POS_HOME;
    end
    m_n = 0; m_ready = 0; m_err = 0; m_strobe = 0; m_settled = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else begin
        mphase   = m_n % UPDATE_DIV;
        macc     = cmd_valid && m_ready;
        mch      = int'(cmd_ch);
        m_err    = macc && (mch >= NUM_CH);
        m_strobe = (m_n >= UPDATE_DIV) && (mphase == NUM_CH);
        if (m_n >= UPDATE_DIV && mphase < NUM_CH)
          m_cur[mphase] = slew_to(m_cur[mphase], m_tgt[mphase]);
        if (m_strobe) begin
          m_settled = 1;
          for (int k = 0; k < NUM_CH; k++) begin
            m_duty[k] = m_cur[k];
            if (m_cur[k] != m_tgt[k]) m_settled = 0;
          end
        end
        if (macc && mch < NUM_CH) begin
          mnew       = clamp(int'(cmd_pos));
          m_tgt[mch] = mnew;
          if (mnew != m_duty[mch]) m_settled = 0;
        end
        m_ready = 1;
        m_n++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NUM_CH*POS_W-1:0] exp_flat;
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      for (int k = 0; k < NUM_CH; k++) exp_flat[k*POS_W +: POS_W] = POS_W'(m_duty[k]);
      check("cmd_ready",     cmd_ready,     m_ready);
      check("cmd_err",       cmd_err,       m_err);
      check("update_strobe", update_strobe, m_strobe);
      check("all_settled",   all_settled,   m_settled);
      check("duty_flat",     duty_flat,     exp_flat);
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  function automatic int slice(int k);
    return int'(duty_flat[k*POS_W +: POS_W]);
  endfunction

  task automatic send(input int ch, input int pos);
    cmd_valid = 1'b1;
    cmd_ch    = 3'(ch);
    cmd_pos   = POS_W'(pos);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_strobe();
    for (int i = 0; i < 2*UPDATE_DIV + 2; i++) begin
      @(negedge clk);
      if (update_strobe) return;
    end
    check("strobe_timeout", 0, 1);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 2*UPDATE_DIV + 2; i++) begin
      if (m_n >= UPDATE_DIV && (m_n % UPDATE_DIV) == p) return;
      @(negedge clk);
    end
    check("phase_timeout", 0, 1);
  endtask

  localparam logic [NUM_CH*POS_W-1:0] ALL_HOME = {NUM_CH{8'd128}};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 1'b0; cmd_ch = '0; cmd_pos = '0;
    reset = 1'b0;
    @(negedge clk);
    cmp_en = 1;
    repeat (2) @(negedge clk);
    check("rst_duty",    duty_flat,     ALL_HOME);
    check("rst_ready",   cmd_ready,     0);
    check("rst_settled", all_settled,   1);
    check("rst_strobe",  update_strobe, 0);

    // Reset release: ready one cycle later, idle frames keep HOME
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_release", cmd_ready, 1);
    wait_strobe();
    check("idle_frame1", duty_flat, ALL_HOME);
    wait_strobe();
    check("idle_frame2", duty_flat, ALL_HOME);

    // Slew: ch2 128 -> 140 in three frames
    send(2, 140);
    wait_strobe(); check("slew_1", slice(2), 132); check("slew_1_settled", all_settled, 0);
    wait_strobe(); check("slew_2", slice(2), 136); check("slew_2_settled", all_settled, 0);
    wait_strobe(); check("slew_3", slice(2), 140); check("slew_3_settled", all_settled, 1);
    check("slew_others", duty_flat, 48'h8080_808C_8080);

    // Clamp: 250 -> 240, ramp by STEP, then a sub-step move
    send(0, 250);
    for (int i = 1; i <= 28; i++) begin
      wait_strobe();
      check("clamp_ramp", slice(0), 128 + 4*i);
    end
    check("clamp_settled", all_settled, 1);
    send(0, 238);
    wait_strobe();
    check("substep", slice(0), 238);
    check("substep_settled", all_settled, 1);

    // Bad index: one-cycle error, nothing changes
    wait_strobe();
    send(7, 50);
    check("bad_idx_err", cmd_err, 1);
    check("bad_idx_settled", all_settled, 1);
    @(negedge clk);
    check("bad_idx_err_clear", cmd_err, 0);
    wait_strobe();
    check("bad_idx_duty", duty_flat, 48'h8080_808C_80EE);

    // Collision: write ch1 during its own scan cycle
    wait_phase(1);
    send(1, 100);
    wait_strobe(); check("collide_old", slice(1), 128);
    wait_strobe(); check("collide_new", slice(1), 124);

    // Random traffic, checked by the model every cycle
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_ch    = 3'($urandom_range(0, 7));
      cmd_pos   = POS_W'($urandom_range(0, 255));
      @(negedge clk);
    end
    cmd_valid = 1'b0;

    // Mid-frame reset while ch3 is ramping
    wait_strobe();
    send(3, (m_cur[3] > 128) ? 16 : 240);
    wait_strobe();
    wait_phase(3);
    #2 reset = 1'b0;
    #1;
    check("midrst_duty",    duty_flat,     ALL_HOME);
    check("midrst_strobe",  update_strobe, 0);
    check("midrst_ready",   cmd_ready,     0);
    check("midrst_err",     cmd_err,       0);
    check("midrst_settled", all_settled,   1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_strobe();
    check("resume_duty_1", duty_flat, ALL_HOME);
    check("resume_settled", all_settled, 1);
    wait_strobe();
    check("resume_duty_2", duty_flat, ALL_HOME);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
